// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-16/CCITT constants for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RECIRC = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first serial CRC step: feedback is the outgoing MSB xor the new bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16 (poly 0x1021). Clear loads 0xFFFF and wins over enable; one bit per enabled edge.
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= '0;
        end else if (i_clr) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= crc16_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words into the config chain, with optional CRC read-back verify.
// Latency: shifting starts one cycle after a word is accepted; word_ready drops while the buffer holds >1 bit.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 40,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int               BC_W      = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN       = CNT_W'(CHAIN_LEN);
    localparam logic [BC_W-1:0]  WORD_BITS = BC_W'(WORD_W);

    state_e             r_state;
    state_e             w_next;
    logic [WORD_W-1:0]  r_buf;
    logic [BC_W-1:0]    r_buf_cnt;
    logic [CNT_W-1:0]   r_load_rem;
    logic [CNT_W-1:0]   r_bit_count;
    logic               r_verify;
    logic               r_head;
    logic               r_shift_en;
    logic               r_pass;
    logic               r_fail;

    logic [15:0]        w_crc_load;
    logic [15:0]        w_crc_rb;
    logic               w_start_acc;
    logic               w_buf_nonempty;
    logic               w_accept;
    logic               w_load_last;
    logic               w_recirc_last;
    logic               w_pass;
    logic               w_fail;
    logic [BC_W-1:0]    w_take;

    assign w_start_acc    = (r_state == IDLE) && start;
    assign w_buf_nonempty = (r_state == LOAD) && (r_buf_cnt != '0);
    // Ready while empty or on the last buffered bit, so consecutive words shift without a bubble.
    assign word_ready     = (r_state == LOAD) && (r_load_rem != '0) && (r_buf_cnt <= BC_W'(1));
    assign w_accept       = word_ready && word_valid;
    assign w_take         = (32'(r_load_rem) >= WORD_W) ? WORD_BITS : BC_W'(r_load_rem);
    // The last enabled edge of LOAD is the cycle the final registered shift_en is presented.
    assign w_load_last    = (r_state == LOAD) && (r_bit_count == LEN) && (r_buf_cnt == '0);
    assign w_recirc_last  = (r_state == RECIRC) && (r_bit_count == LEN - CNT_W'(1));

    assign w_pass = (r_state == DONE) && r_verify && (w_crc_rb == w_crc_load);
    assign w_fail = (r_state == DONE) && r_verify && (w_crc_rb != w_crc_load);

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)         w_next = LOAD;
            LOAD:    if (w_load_last)   w_next = r_verify ? RECIRC : DONE;
            RECIRC:  if (w_recirc_last) w_next = DONE;
            DONE:                       w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_buf       <= '0;
            r_buf_cnt   <= '0;
            r_load_rem  <= '0;
            r_bit_count <= '0;
            r_verify    <= 1'b0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_shift_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_verify    <= verify_en;
                        r_bit_count <= '0;
                        r_load_rem  <= LEN;
                        r_buf_cnt   <= '0;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_buf_nonempty) begin
                        r_head     <= r_buf[0];
                        r_shift_en <= 1'b1;
                        if (r_bit_count != LEN) begin
                            r_bit_count <= r_bit_count + CNT_W'(1);
                        end
                    end
                    if (w_accept) begin
                        r_buf      <= word_data;
                        r_buf_cnt  <= w_take;
                        r_load_rem <= r_load_rem - CNT_W'(w_take);
                    end else if (w_buf_nonempty) begin
                        r_buf     <= r_buf >> 1;
                        r_buf_cnt <= r_buf_cnt - BC_W'(1);
                    end
                    if (w_load_last && r_verify) begin
                        r_bit_count <= '0;
                    end
                end
                RECIRC: begin
                    if (r_bit_count != LEN) begin
                        r_bit_count <= r_bit_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_pass <= w_pass;
                    r_fail <= w_fail;
                end
                default: ;
            endcase
        end
    end

    ccff_crc16_serial u_crc_load (
        .i_clk   (prog_clk),
        .i_rst_n (pReset),
        .i_clr   (w_start_acc),
        .i_en    (w_buf_nonempty),
        .i_bit   (r_buf[0]),
        .o_crc   (w_crc_load)
    );

    ccff_crc16_serial u_crc_rb (
        .i_clk   (prog_clk),
        .i_rst_n (pReset),
        .i_clr   (w_start_acc),
        .i_en    (r_state == RECIRC),
        .i_bit   (ccff_tail),
        .o_crc   (w_crc_rb)
    );

    // During read-back the chain is closed into a loop so its contents survive the verify.
    assign ccff_head     = (r_state == RECIRC) ? ccff_tail : r_head;
    assign ccff_shift_en = (r_state == RECIRC) || r_shift_en;
    assign busy          = (r_state == LOAD) || (r_state == RECIRC);
    assign done          = (r_state == DONE);
    assign pass          = r_pass || w_pass;
    assign fail          = r_fail || w_fail;
    assign bit_count     = r_bit_count;

endmodule
